audio_i2s_tx: RTL and testbench
===============================

# audio_i2s_tx

Serialises the synthesizer's stereo sample stream into a standard I2S (Philips) frame for the audio DAC codec. The block is the I2S bus master and generates AUD_BCLK, AUD_DACLRCK and AUD_DACDAT from AUDIO_CLK. It accepts one stereo sample per frame through a valid/ready handshake and returns a frame-start pulse that drives the synthesizer's sample trigger. It sits between the synthesizer's lsound_out/rsound_out outputs and the codec pins.

## Interface
- DATA_WIDTH, 24: sample width per channel, two's complement.
- SLOT_BITS, 32: BCLK periods per channel slot. Must be ≥ DATA_WIDTH + 1.
- BCLK_DIV, 4: AUDIO_CLK cycles per BCLK period. Must be even and ≥ 2.
- AUDIO_CLK  in  1  sole clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- lsound_in  in  DATA_WIDTH  left sample.
- rsound_in  in  DATA_WIDTH  right sample.
- sample_valid  in  1  producer offers {lsound_in, rsound_in}.
- sample_ready  out  1  one-entry holding buffer empty.
- AUD_BCLK  out  1  bit clock.
- AUD_DACLRCK  out  1  word select: 0 = left, 1 = right.
- AUD_DACDAT  out  1  serial data, MSB first.
- frame_start  out  1  one-cycle pulse when a frame is loaded into the shifter.
- underrun  out  1  one-cycle pulse when a frame loads while the buffer is empty.

## Operation
- **Divider.** div_cnt runs 0..BCLK_DIV-1 and wraps. The fall event is div_cnt == BCLK_DIV-1. AUD_BCLK is registered: 1 while next div_cnt ≥ BCLK_DIV/2, otherwise 0.
- **Bit counter.** bit_cnt runs 0..2·SLOT_BITS-1 and advances on each fall event, wrapping to 0.
- **Word select.** AUD_DACLRCK = (bit_cnt ≥ SLOT_BITS), registered with bit_cnt.
- **Load edge.** The load edge is the fall event that takes bit_cnt from 0 to 1. This gives the I2S one-BCLK delay of the MSB after the LRCK edge.
  - The shifter (2·SLOT_BITS bits) loads {L, zeros(SLOT_BITS-DATA_WIDTH), R, zeros(SLOT_BITS-DATA_WIDTH)}, taken from the buffer.
  - If the buffer is empty, the shifter loads the last transmitted frame instead and underrun pulses.
  - frame_start pulses on every load edge.
- **Shift.** On every other fall event the shifter shifts left by one. AUD_DACDAT is always the shifter MSB.
- **Handshake.**
  - sample_ready = buffer empty.
  - A transfer occurs when sample_valid && sample_ready; the buffer captures both channels and becomes full on the next cycle.
  - A load edge empties the buffer.
  - If a transfer and a load edge fall in the same cycle while the buffer is empty, the load repeats the old frame (underrun pulses). The new sample is stored and transmitted on the next frame.
  - A full buffer is never overwritten; the producer holds its data until ready.
- **Reset** (asynchronous, any point mid-frame):
  - div_cnt, bit_cnt, shifter and held frame are cleared to 0.
  - Buffer is empty.
  - AUD_BCLK = 0, AUD_DACLRCK = 0, AUD_DACDAT = 0, frame_start = 0, underrun = 0, sample_ready = 1.
  - The first load edge after reset transmits zeros (plus underrun) unless a sample was accepted beforehand.

## Timing
- All outputs are registered. AUD_BCLK falls, and AUD_DACLRCK/AUD_DACDAT change, in the same AUDIO_CLK cycle.
- The codec samples data on the AUD_BCLK rise, BCLK_DIV/2 cycles after the change.
- Frame period is 2·SLOT_BITS·BCLK_DIV cycles: 256 with defaults, which is 48 kHz at AUDIO_CLK = 12.288 MHz.
- The first load edge after reset release occurs at cycle BCLK_DIV·2-1 (cycle 7 with defaults). Later load edges follow every frame period.
- Latency: data accepted before a load edge has its left MSB on AUD_DACDAT in the load-edge cycle. The right MSB follows SLOT_BITS BCLKs later.
- Within a frame, the right channel's last padding bit is output at bit_cnt = 0 of the next frame.
- sample_ready rises in the cycle after a load edge when the buffer was full.

## Structure
- Shared package audio_pkg holds AUDIO_DATA_WIDTH = 24, I2S_SLOT_BITS = 32, and the stereo sample typedef {left, right}. The synthesizer output side uses the same definitions.
- Sub-module i2s_bclk_gen contains the divider and bit counter and produces fall_evt, load_evt, AUD_BCLK and AUD_DACLRCK.
- The top level contains the holding buffer, the shifter and the handshake.

## Test plan
- **Reset.** Hold reset_n = 0 mid-frame. All outputs must match the reset values within the same cycle. After release, the first load_evt must occur at cycle 7 (defaults).
- **Single frame.** Send L = 0xABCDEF, R = 0x123456 before the first load. Capturing AUD_DACDAT on each AUD_BCLK rise must give 0, then 0xABCDEF MSB-first, 8 zeros, 0x123456, 7 zeros. AUD_DACLRCK must toggle at bit 0 and bit 32.
- **Underrun.** After one frame of 0x7FFFFF/0x800000, send nothing. The next frame must repeat 0x7FFFFF/0x800000, and underrun must pulse once, coincident with frame_start.
- **Backpressure.** Hold sample_valid = 1 with incrementing data. Exactly one transfer per frame; sample_ready is low between transfers. No sample is lost or duplicated across 10 frames.
- **Simultaneous event.** Assert valid on the load-edge cycle with the buffer empty. The old frame repeats with underrun, and the new sample appears in the following frame.
- **Parameter corner.** With BCLK_DIV = 2, the frame period must be 128 cycles and the bit pattern must be identical to the single-frame case.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio definitions for the synthesizer output side and the I2S transmitter.
package audio_pkg;

  localparam int unsigned AUDIO_DATA_WIDTH = 24;
  localparam int unsigned I2S_SLOT_BITS    = 32;

  typedef struct packed {
    logic [AUDIO_DATA_WIDTH-1:0] left;
    logic [AUDIO_DATA_WIDTH-1:0] right;
  } stereo_sample_t;

endpackage

// File: rtl/i2s_bclk_gen.sv
// I2S bit-clock divider and frame bit counter; flags the BCLK fall and the frame load edge.
module i2s_bclk_gen
  import audio_pkg::*;
#(
  parameter int unsigned SLOT_BITS = I2S_SLOT_BITS,
  parameter int unsigned BCLK_DIV  = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic fall_evt,
  output logic load_evt,
  output logic AUD_BCLK,
  output logic AUD_DACLRCK
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
  localparam int unsigned DIV_W      = $clog2(BCLK_DIV);
  localparam int unsigned BIT_W      = $clog2(FRAME_BITS);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  logic [BIT_W-1:0] bit_cnt;
  logic [BIT_W-1:0] bit_nxt;
  logic             started;

  // The first BCLK after reset is idle, so the first load lands two BCLKs after release.
  always_comb begin
    fall_evt = (div_cnt == DIV_W'(BCLK_DIV - 1));
    load_evt = fall_evt && started && (bit_cnt == '0);
    div_nxt  = fall_evt ? '0 : div_cnt + DIV_W'(1);
    bit_nxt  = bit_cnt;
    if (fall_evt && started) begin
      bit_nxt = (bit_cnt == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt + BIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      started     <= 1'b0;
      AUD_BCLK    <= 1'b0;
      AUD_DACLRCK <= 1'b0;
    end else begin
      div_cnt     <= div_nxt;
      bit_cnt     <= bit_nxt;
      AUD_BCLK    <= (div_nxt >= DIV_W'(BCLK_DIV / 2));
      AUD_DACLRCK <= (bit_nxt >= BIT_W'(SLOT_BITS));
      if (fall_evt) begin
        started <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// I2S (Philips) master transmitter: one-entry stereo holding buffer feeding a frame shifter.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AUDIO_DATA_WIDTH,
  parameter int unsigned SLOT_BITS  = I2S_SLOT_BITS,
  parameter int unsigned BCLK_DIV   = 4
) (
  input  logic                  AUDIO_CLK,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] lsound_in,
  input  logic [DATA_WIDTH-1:0] rsound_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  AUD_BCLK,
  output logic                  AUD_DACLRCK,
  output logic                  AUD_DACDAT,
  output logic                  frame_start,
  output logic                  underrun
);

  localparam int unsigned FRAME_BITS = 2 * SLOT_BITS;
  localparam int unsigned PAD_BITS   = SLOT_BITS - DATA_WIDTH;

  logic                  fall_evt;
  logic                  load_evt;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] buf_l;
  logic [DATA_WIDTH-1:0] buf_r;
  logic [FRAME_BITS-1:0] buf_frame;
  logic [FRAME_BITS-1:0] last_frame;
  logic [FRAME_BITS-1:0] shifter;

  i2s_bclk_gen #(
    .SLOT_BITS (SLOT_BITS),
    .BCLK_DIV  (BCLK_DIV)
  ) u_bclk_gen (
    .clk         (AUDIO_CLK),
    .rst_n       (reset_n),
    .fall_evt    (fall_evt),
    .load_evt    (load_evt),
    .AUD_BCLK    (AUD_BCLK),
    .AUD_DACLRCK (AUD_DACLRCK)
  );

  // sample_ready doubles as the buffer-empty flag.
  assign xfer       = sample_valid && sample_ready;
  assign buf_frame  = {buf_l, {PAD_BITS{1'b0}}, buf_r, {PAD_BITS{1'b0}}};
  assign AUD_DACDAT = shifter[FRAME_BITS-1];

  // An empty buffer at the load edge replays the last frame, even if a sample arrives that cycle.
  always_ff @(posedge AUDIO_CLK or negedge reset_n) begin
    if (!reset_n) begin
      buf_l        <= '0;
      buf_r        <= '0;
      last_frame   <= '0;
      shifter      <= '0;
      sample_ready <= 1'b1;
      frame_start  <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      frame_start <= load_evt;
      underrun    <= load_evt && sample_ready;
      if (load_evt) begin
        if (!sample_ready) begin
          shifter    <= buf_frame;
          last_frame <= buf_frame;
        end else begin
          shifter <= last_frame;
        end
      end else if (fall_evt) begin
        shifter <= {shifter[FRAME_BITS-2:0], 1'b0};
      end
      if (xfer) begin
        buf_l        <= lsound_in;
        buf_r        <= rsound_in;
        sample_ready <= 1'b0;
      end else if (load_evt) begin
        sample_ready <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx: scoreboard of accepted samples against the serial frames.
module tb_audio_i2s_tx;
  import audio_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [23:0] lsound;
  logic [23:0] rsound;
  logic        sample_valid;
  logic        sample_ready, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, frame_start, underrun;

  logic        reset_n2;
  logic [23:0] l2, r2;
  logic        valid2;
  logic        ready2, bclk2, lrck2, dat2, fs2, ur2;

  always #5 clk = ~clk;

  audio_i2s_tx dut (
    .AUDIO_CLK(clk), .reset_n(reset_n), .lsound_in(lsound), .rsound_in(rsound),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .AUD_BCLK(AUD_BCLK),
    .AUD_DACLRCK(AUD_DACLRCK), .AUD_DACDAT(AUD_DACDAT), .frame_start(frame_start),
    .underrun(underrun)
  );

  audio_i2s_tx #(.DATA_WIDTH(24), .SLOT_BITS(32), .BCLK_DIV(2)) dut2 (
    .AUDIO_CLK(clk), .reset_n(reset_n2), .lsound_in(l2), .rsound_in(r2),
    .sample_valid(valid2), .sample_ready(ready2), .AUD_BCLK(bclk2),
    .AUD_DACLRCK(lrck2), .AUD_DACDAT(dat2), .frame_start(fs2), .underrun(ur2)
  );

  int checks = 0;
  int failures = 0;

  stereo_sample_t sb_q[$];
  logic [63:0] last_exp, cur_exp, done_exp, done_bits, done_lr;
  logic [64:0] win;
  logic [63:0] lrwin;
  logic        done_lead, prev_bclk;
  logic        cur_exp_under, cur_obs_under, done_exp_under, done_obs_under;
  int cyc, loads, frames_done, first_load_edge, last_load_edge, load_period;
  int xfers, stray_underrun, ready_hi, sb_overflow;
  bit auto_inc;

  localparam logic [63:0] LR_PATTERN = 64'h0000_0001_FFFF_FFFE;

  task automatic model_clear();
    sb_q.delete();
    last_exp = '0; cur_exp = '0; win = '0; lrwin = '0; prev_bclk = 1'b0;
    cyc = 0; loads = 0; frames_done = 0; stray_underrun = 0; ready_hi = 0;
    sb_overflow = 0; load_period = 0; last_load_edge = 0; first_load_edge = -1;
  endtask

  // One clock: drive-side transfer bookkeeping plus serial capture and load-edge scoreboard.
  task automatic step();
    logic will_xfer;
    stereo_sample_t s;
    will_xfer = sample_valid && sample_ready;
    @(posedge clk); #1;
    cyc++;
    if (AUD_BCLK && !prev_bclk) begin
      win   = {win[63:0], AUD_DACDAT};
      lrwin = {lrwin[62:0], AUD_DACLRCK};
    end
    prev_bclk = AUD_BCLK;
    if (underrun && !frame_start) stray_underrun++;
    if (frame_start) begin
      if (loads > 0) begin
        done_bits = win[63:0]; done_lead = win[64]; done_lr = lrwin;
        done_exp = cur_exp; done_exp_under = cur_exp_under; done_obs_under = cur_obs_under;
        frames_done++;
        load_period = (cyc - 1) - last_load_edge;
      end else begin
        first_load_edge = cyc - 1;
      end
      last_load_edge = cyc - 1;
      loads++;
      cur_obs_under = underrun;
      cur_exp_under = (sb_q.size() == 0);
      if (sb_q.size() != 0) begin
        s = sb_q.pop_front();
        last_exp = {s.left, 8'h00, s.right, 8'h00};
      end
      cur_exp = last_exp;
    end
    if (will_xfer) begin
      s.left = lsound; s.right = rsound;
      sb_q.push_back(s);
      xfers++;
      if (auto_inc) begin
        lsound = lsound + 24'd1;
        rsound = rsound - 24'd1;
      end
    end
    if (sample_ready) ready_hi++;
    if (sb_q.size() > 1) sb_overflow++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    model_clear();
    reset_n = 1'b1;
  endtask

  task automatic send(input logic [23:0] l, input logic [23:0] r, output bit ok);
    int x0;
    x0 = xfers; ok = 1'b0;
    lsound = l; rsound = r; sample_valid = 1'b1;
    for (int i = 0; i < 600; i++) begin
      step();
      if (xfers != x0) begin ok = 1'b1; break; end
    end
    sample_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (frames_done >= target) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    bit ok, found;
    do_reset();
    send(24'hFFFFFF, 24'hFFFFFF, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL reset_send1: accepted=%0b expected 1", ok); end
    send(24'hFFFFFF, 24'hFFFFFF, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL reset_send2: accepted=%0b expected 1", ok); end
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (AUD_BCLK && AUD_DACDAT && AUD_DACLRCK && !sample_ready) begin found = 1'b1; break; end
      step();
    end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL reset_midframe_state: found=%0b expected 1", found); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (AUD_BCLK !== 1'b0) begin failures++; $display("FAIL reset_bclk: got %b expected 0", AUD_BCLK); end
    checks++; if (AUD_DACLRCK !== 1'b0) begin failures++; $display("FAIL reset_lrck: got %b expected 0", AUD_DACLRCK); end
    checks++; if (AUD_DACDAT !== 1'b0) begin failures++; $display("FAIL reset_dat: got %b expected 0", AUD_DACDAT); end
    checks++; if (frame_start !== 1'b0) begin failures++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
    checks++; if (underrun !== 1'b0) begin failures++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    checks++; if (sample_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", sample_ready); end
    @(posedge clk); #1;
    checks++; if (AUD_BCLK !== 1'b0) begin failures++; $display("FAIL reset_hold_bclk: got %b expected 0", AUD_BCLK); end
    @(negedge clk);
    model_clear();
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (loads > 0) break;
      step();
    end
    checks++; if (first_load_edge != 7) begin failures++; $display("FAIL reset_first_load: cycle %0d expected 7", first_load_edge); end
    checks++; if (cur_obs_under !== 1'b1) begin failures++; $display("FAIL reset_first_underrun: got %b expected 1", cur_obs_under); end
    wait_frames(1, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL reset_frame_timeout: ok=%0b expected 1", ok); end
    checks++; if (done_bits !== 64'h0) begin failures++; $display("FAIL reset_zero_frame: got %h expected 0", done_bits); end
  endtask

  task automatic test_single_frame();
    bit ok;
    do_reset();
    send(24'hABCDEF, 24'h123456, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_send: accepted=%0b expected 1", ok); end
    wait_frames(1, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_timeout: ok=%0b expected 1", ok); end
    checks++; if (done_lead !== 1'b0) begin failures++; $display("FAIL single_lead_bit: got %b expected 0", done_lead); end
    checks++; if (done_bits !== 64'hABCDEF00_12345600) begin failures++; $display("FAIL single_bits: got %h expected abcdef0012345600", done_bits); end
    checks++; if (done_bits !== done_exp) begin failures++; $display("FAIL single_scoreboard: got %h expected %h", done_bits, done_exp); end
    checks++; if (done_lr !== LR_PATTERN) begin failures++; $display("FAIL single_lrck: got %h expected %h", done_lr, LR_PATTERN); end
    checks++; if (done_obs_under !== 1'b0) begin failures++; $display("FAIL single_underrun: got %b expected 0", done_obs_under); end
  endtask

  task automatic test_underrun();
    bit ok;
    int f0;
    f0 = frames_done;
    send(24'h7FFFFF, 24'h800000, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL under_send: accepted=%0b expected 1", ok); end
    wait_frames(f0 + 2, ok);
    checks++; if (done_bits !== 64'h7FFFFF00_80000000) begin failures++; $display("FAIL under_first_bits: got %h expected 7fffff0080000000", done_bits); end
    checks++; if (done_obs_under !== 1'b0) begin failures++; $display("FAIL under_first_flag: got %b expected 0", done_obs_under); end
    wait_frames(f0 + 3, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL under_timeout: ok=%0b expected 1", ok); end
    checks++; if (done_bits !== 64'h7FFFFF00_80000000) begin failures++; $display("FAIL under_repeat_bits: got %h expected 7fffff0080000000", done_bits); end
    checks++; if (done_obs_under !== done_exp_under) begin failures++; $display("FAIL under_repeat_flag: got %b expected %b", done_obs_under, done_exp_under); end
    checks++; if (stray_underrun != 0) begin failures++; $display("FAIL under_stray: got %0d expected 0", stray_underrun); end
    checks++; if (load_period != 256) begin failures++; $display("FAIL under_period: got %0d expected 256", load_period); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int x0, l0, r0;
    logic [23:0] prev_l;
    lsound = 24'h000100; rsound = 24'hFFF000;
    auto_inc = 1'b1; sample_valid = 1'b1;
    wait_frames(frames_done + 2, ok);
    x0 = xfers; l0 = loads; r0 = ready_hi;
    prev_l = 24'h0;
    for (int k = 0; k < 10; k++) begin
      wait_frames(frames_done + 1, ok);
      checks++; if (done_bits !== done_exp) begin failures++; $display("FAIL b2b_frame%0d: got %h expected %h", k, done_bits, done_exp); end
      checks++; if (done_obs_under !== 1'b0) begin failures++; $display("FAIL b2b_underrun%0d: got %b expected 0", k, done_obs_under); end
      if (k > 0) begin
        checks++; if (done_bits[63:40] !== prev_l + 24'd1) begin failures++; $display("FAIL b2b_seq%0d: got %h expected %h", k, done_bits[63:40], prev_l + 24'd1); end
      end
      prev_l = done_bits[63:40];
    end
    checks++; if ((xfers - x0) != (loads - l0)) begin failures++; $display("FAIL b2b_xfer_count: got %0d expected %0d", xfers - x0, loads - l0); end
    checks++; if ((ready_hi - r0) != 10) begin failures++; $display("FAIL b2b_ready_cycles: got %0d expected 10", ready_hi - r0); end
    checks++; if (sb_overflow != 0) begin failures++; $display("FAIL b2b_overwrite: got %0d expected 0", sb_overflow); end
    sample_valid = 1'b0; auto_inc = 1'b0;
  endtask

  task automatic test_simultaneous();
    bit ok;
    int f, x0;
    wait_frames(frames_done + 1, ok);
    checks++; if (sample_ready !== 1'b1) begin failures++; $display("FAIL simul_empty: ready=%b expected 1", sample_ready); end
    for (int i = 0; i < 300; i++) begin
      if (cyc == last_load_edge + 256) break;
      step();
    end
    lsound = 24'h5A5A5A; rsound = 24'hA5A5A5; sample_valid = 1'b1;
    x0 = xfers;
    step();
    sample_valid = 1'b0;
    checks++; if (frame_start !== 1'b1) begin failures++; $display("FAIL simul_on_load: frame_start=%b expected 1", frame_start); end
    checks++; if (underrun !== 1'b1) begin failures++; $display("FAIL simul_underrun: got %b expected 1", underrun); end
    checks++; if (xfers != x0 + 1) begin failures++; $display("FAIL simul_accept: got %0d expected %0d", xfers, x0 + 1); end
    f = frames_done;
    wait_frames(f + 1, ok);
    checks++; if (done_bits !== done_exp) begin failures++; $display("FAIL simul_repeat: got %h expected %h", done_bits, done_exp); end
    wait_frames(f + 2, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL simul_timeout: ok=%0b expected 1", ok); end
    checks++; if (done_bits !== 64'h5A5A5A00_A5A5A500) begin failures++; $display("FAIL simul_new_bits: got %h expected 5a5a5a00a5a5a500", done_bits); end
    checks++; if (done_obs_under !== 1'b0) begin failures++; $display("FAIL simul_new_flag: got %b expected 0", done_obs_under); end
  endtask

  task automatic test_param_corner();
    logic [64:0] w2;
    logic pb, wx, u1;
    int c, nload, e1, e2;
    bit acc;
    reset_n2 = 1'b0; l2 = 24'hABCDEF; r2 = 24'h123456; valid2 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n2 = 1'b1;
    w2 = '0; pb = 1'b0; c = 0; nload = 0; acc = 1'b0; e1 = -1; e2 = -1; u1 = 1'bx;
    for (int i = 0; i < 400; i++) begin
      if (nload >= 2) break;
      wx = valid2 && ready2;
      @(posedge clk); #1;
      c++;
      if (wx) begin valid2 = 1'b0; acc = 1'b1; end
      if (bclk2 && !pb) w2 = {w2[63:0], dat2};
      pb = bclk2;
      if (fs2) begin
        if (nload == 0) begin e1 = c - 1; u1 = ur2; end
        else e2 = c - 1;
        nload++;
      end
    end
    checks++; if (acc !== 1'b1) begin failures++; $display("FAIL div2_accept: got %0b expected 1", acc); end
    checks++; if (e1 != 3) begin failures++; $display("FAIL div2_first_load: cycle %0d expected 3", e1); end
    checks++; if ((e2 - e1) != 128) begin failures++; $display("FAIL div2_period: got %0d expected 128", e2 - e1); end
    checks++; if (u1 !== 1'b0) begin failures++; $display("FAIL div2_underrun: got %b expected 0", u1); end
    checks++; if (w2 !== {1'b0, 64'hABCDEF00_12345600}) begin failures++; $display("FAIL div2_bits: got %h expected 0abcdef0012345600", w2); end
  endtask

  initial begin
    reset_n = 1'b0; reset_n2 = 1'b0;
    lsound = '0; rsound = '0; sample_valid = 1'b0;
    l2 = '0; r2 = '0; valid2 = 1'b0;
    auto_inc = 1'b0; xfers = 0;
    cur_exp_under = 1'b0; cur_obs_under = 1'b0;
    done_exp_under = 1'b0; done_obs_under = 1'b0;
    done_bits = '0; done_exp = '0; done_lr = '0; done_lead = 1'b0;
    model_clear();
    test_reset();
    test_single_frame();
    test_underrun();
    test_back_to_back();
    test_simultaneous();
    test_param_corner();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
